// File: rtl/ddr_axi_pkg.sv
// Shared AXI3 constants and state encoding for the DDR3 ring-partition
// writer/reader pair.
package ddr_axi_pkg;

    localparam int ADDR_W    = 26;
    localparam int MAX_BURST = 16;
    localparam int FREE_W    = 11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [3:0] CACHE      = 4'b0011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_CALC,
        RD_AR,
        RD_DATA,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/ddr_rd_burst_calc.sv
// Burst length for the next read: the minimum of the burst cap, words
// available, output FIFO space and words left before the next 4KB page.
module ddr_rd_burst_calc
    import ddr_axi_pkg::*;
#(
    parameter int AW   = ddr_axi_pkg::ADDR_W,
    parameter int MAXB = ddr_axi_pkg::MAX_BURST
) (
    input  logic [AW-1:0]     rd_ptr_i,
    input  logic [AW-1:0]     wr_ptr_i,
    input  logic [FREE_W-1:0] fifo_free_i,
    output logic [AW-1:0]     avail_o,
    output logic [FREE_W-1:0] len_o
);

    logic [FREE_W-1:0] page_left;

    always_comb begin
        avail_o   = wr_ptr_i - rd_ptr_i;
        page_left = 11'd1024 - {1'b0, rd_ptr_i[9:0]};
        len_o     = FREE_W'(MAXB);
        if (avail_o < AW'(len_o)) begin
            len_o = avail_o[FREE_W-1:0];
        end
        if (fifo_free_i < len_o) begin
            len_o = fifo_free_i;
        end
        // 2^AW is a multiple of 1024, so this also stops bursts at the partition end
        if (page_left < len_o) begin
            len_o = page_left;
        end
    end

endmodule

// File: rtl/ddr_axi_reader.sv
// AXI3 read master draining the DDR3 ring partition into the output FIFO,
// one adaptive burst outstanding at a time.
module ddr_axi_reader
    import ddr_axi_pkg::*;
#(
    parameter logic [31:0] DDR3_BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W         = ddr_axi_pkg::ADDR_W,
    parameter int          MAX_BURST      = ddr_axi_pkg::MAX_BURST
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_enable,
    input  logic [ADDR_W-1:0] wr_word_ptr,
    input  logic              reset_addr,
    output logic [ADDR_W-1:0] rd_word_ptr,
    output logic [31:0]       fifo_din,
    output logic              fifo_wr,
    input  logic [10:0]       fifo_free,
    output logic [31:0]       m_axi_araddr,
    output logic [5:0]        m_axi_arid,
    output logic [3:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [1:0]        m_axi_arburst,
    output logic [2:0]        m_axi_arsize,
    output logic [3:0]        m_axi_arcache,
    output logic [1:0]        m_axi_arlock,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    input  logic [31:0]       m_axi_rdata,
    input  logic [5:0]        m_axi_rid,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              axi_busy,
    output logic              rresp_err,
    output logic              proto_err
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [5:0]        arid_q, arid_d;
    logic [3:0]        arlen_q, arlen_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [10:0]       beats_exp_q, beats_exp_d;
    logic [10:0]       beat_cnt_q, beat_cnt_d;
    logic              done_cnt_q, done_cnt_d;
    logic [31:0]       fifo_din_q, fifo_din_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic              rresp_err_q, rresp_err_d;
    logic              proto_err_q, proto_err_d;

    logic [ADDR_W-1:0] avail;
    logic [10:0]       len;

    ddr_rd_burst_calc #(
        .AW   (ADDR_W),
        .MAXB (MAX_BURST)
    ) u_calc (
        .rd_ptr_i    (rd_ptr_q),
        .wr_ptr_i    (wr_word_ptr),
        .fifo_free_i (fifo_free),
        .avail_o     (avail),
        .len_o       (len)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= RD_IDLE;
            rd_ptr_q    <= '0;
            arid_q      <= '0;
            arlen_q     <= '0;
            araddr_q    <= {DDR3_BASE_ADDR[31:28], {ADDR_W{1'b0}}, 2'b00};
            beats_exp_q <= '0;
            beat_cnt_q  <= '0;
            done_cnt_q  <= 1'b0;
            fifo_din_q  <= '0;
            fifo_wr_q   <= 1'b0;
            rresp_err_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            arid_q      <= arid_d;
            arlen_q     <= arlen_d;
            araddr_q    <= araddr_d;
            beats_exp_q <= beats_exp_d;
            beat_cnt_q  <= beat_cnt_d;
            done_cnt_q  <= done_cnt_d;
            fifo_din_q  <= fifo_din_d;
            fifo_wr_q   <= fifo_wr_d;
            rresp_err_q <= rresp_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        arid_d      = arid_q;
        arlen_d     = arlen_q;
        araddr_d    = araddr_q;
        beats_exp_d = beats_exp_q;
        beat_cnt_d  = beat_cnt_q;
        done_cnt_d  = done_cnt_q;
        fifo_din_d  = fifo_din_q;
        fifo_wr_d   = 1'b0;
        rresp_err_d = rresp_err_q;
        proto_err_d = proto_err_q;
        case (state_q)
            RD_IDLE: begin
                if (reset_addr) begin
                    rd_ptr_d = wr_word_ptr;
                end else if (rd_enable && (avail != '0) && (fifo_free != '0)) begin
                    state_d = RD_CALC;
                end
            end
            RD_CALC: begin
                if (len == '0) begin
                    state_d = RD_IDLE;
                end else begin
                    arlen_d     = 4'(len - 11'd1);
                    beats_exp_d = len;
                    araddr_d    = {DDR3_BASE_ADDR[31:28], rd_ptr_q, 2'b00};
                    arid_d      = arid_q + 6'd1;
                    beat_cnt_d  = '0;
                    state_d     = RD_AR;
                end
            end
            RD_AR: begin
                if (m_axi_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    fifo_din_d = m_axi_rdata;
                    fifo_wr_d  = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    beat_cnt_d = beat_cnt_q + 11'd1;
                    if (m_axi_rresp != RESP_OKAY) begin
                        rresp_err_d = 1'b1;
                    end
                    if (m_axi_rid != arid_q) begin
                        proto_err_d = 1'b1;
                    end
                    // Either terminator alone ends the burst; disagreement is a protocol fault
                    if (m_axi_rlast || (beat_cnt_d == beats_exp_q)) begin
                        state_d    = RD_DONE;
                        done_cnt_d = 1'b0;
                        if (m_axi_rlast != (beat_cnt_d == beats_exp_q)) begin
                            proto_err_d = 1'b1;
                        end
                    end
                end
            end
            RD_DONE: begin
                done_cnt_d = 1'b1;
                if (done_cnt_q) begin
                    state_d = RD_IDLE;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        m_axi_arvalid = (state_q == RD_AR);
        m_axi_rready  = (state_q == RD_DATA);
        axi_busy      = (state_q != RD_IDLE);
    end

    assign rd_word_ptr   = rd_ptr_q;
    assign fifo_din      = fifo_din_q;
    assign fifo_wr       = fifo_wr_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arcache = CACHE;
    assign m_axi_arlock  = 2'b00;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign rresp_err     = rresp_err_q;
    assign proto_err     = proto_err_q;

endmodule

// File: doc/ddr_axi_reader.md
Name: ddr_axi_reader

Overview:
- AXI3 read master that drains the DDR3 ring partition filled by the FIFO-to-DDR writer. It streams the words, in order, into a downstream output FIFO.
- It tracks its own read pointer against the writer's word pointer. It issues adaptive bursts of 1–16 beats, each bounded by available data, FIFO space and the 4KB boundary. It wraps at the partition end.
- It sits beside the writer on the same PS HP port, with one burst outstanding at a time.

Parameters:
- DDR3_BASE_ADDR, 32'h3000_0000, partition base; bits [31:28] form the address prefix.
- ADDR_W, 26, word-pointer width; the partition is 2^ADDR_W 32-bit words.
- MAX_BURST, 16, maximum beats per burst (AXI3 arlen 4 bits).

Ports:
- clk  in  1  single clock domain.
- rstn  in  1  reset, synchronous, active-low.
- rd_enable  in  1  allows new bursts; an in-flight burst always completes.
- wr_word_ptr  in  26  writer's next-write word index (free-running modulo 2^26).
- reset_addr  in  1  PS request: discard unread data (rd_ptr := wr_word_ptr).
- rd_word_ptr  out  26  next word index to read; fed back to the writer for overrun guarding.
- fifo_din  out  32  read data to the output FIFO.
- fifo_wr  out  1  output FIFO write strobe.
- fifo_free  in  11  free entries in the output FIFO.
- m_axi_araddr  out  32  {BASE[31:28], rd_ptr, 2'b00} latched at burst issue.
- m_axi_arid  out  6  increments per burst.
- m_axi_arlen  out  4  beats-1.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_arburst/arsize/arcache/arlock/arprot/arqos  out  2/3/4/2/3/4  constants: INCR, 4 bytes, 4'b0011, 0, 0, 0.
- m_axi_rdata  in  32  read data.
- m_axi_rid  in  6  read ID.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  read valid.
- m_axi_rready  out  1  read ready.
- axi_busy  out  1  high from CALC through DONE.
- rresp_err  out  1  sticky: a non-OKAY rresp was seen.
- proto_err  out  1  sticky: rlast or rid mismatch.

Behaviour:
- Reset (rstn low at a clk edge): state IDLE.
  - arvalid, rready, fifo_wr, axi_busy, rresp_err, proto_err = 0.
  - arid = 0, arlen = 0, rd_ptr = 0, araddr = {BASE[31:28], 26'd0, 2'b00}.
  - Reset mid-burst abandons the burst immediately. Stray R beats after reset are ignored because rready = 0.
- avail = (wr_word_ptr - rd_ptr) mod 2^26, computed as 26-bit wrapping subtraction.
- len = min(16, avail, fifo_free, 1024 - rd_ptr[9:0]).
  - The 1024-word term prevents 4KB crossings. It also covers the partition-end wrap, because 2^26 is a multiple of 1024.
  - Compute len as an 11-bit unsigned value.
- State transitions:
  - IDLE: if reset_addr, set rd_ptr <= wr_word_ptr and stay in IDLE. Otherwise, if rd_enable and avail != 0 and fifo_free != 0, go to CALC. reset_addr is honoured only in IDLE.
  - CALC: register arlen <= len-1, beats_exp <= len, araddr, and arid <= arid+1. Go to AR.
  - AR: hold arvalid = 1 with araddr, arlen and arid stable until arready. On arvalid & arready, drop arvalid next cycle and go to DATA.
  - DATA: rready = 1; space is already reserved, so no backpressure. Each rvalid beat does the following:
    - fifo_din <= rdata and fifo_wr <= 1 (one-cycle registered latency).
    - rd_ptr <= rd_ptr + 1, wrapping at 2^26.
    - beat counter increments.
    - rresp != 2'b00 sets rresp_err; the data is still written.
    - rid != arid sets proto_err.
  - DATA exit: on rlast, or when the beat count reaches beats_exp, go to DONE.
    - rlast before beats_exp sets proto_err.
    - Reaching beats_exp without rlast also sets proto_err; further beats are then ignored with rready = 0.
  - DONE: wait 2 cycles so the last FIFO write lands and fifo_free settles, then go to IDLE.
- arid increments by exactly 1 per issued burst and wraps at 64.
- rd_word_ptr equals rd_ptr and updates on each accepted beat.
- Empty case (avail = 0) or full case (fifo_free = 0): no AR is issued; wait in IDLE.

Decomposition:
- Shared package ddr_axi_pkg:
  - ADDR_W.
  - AXI constants: BURST_INCR = 2'b01, SIZE_4B = 3'b010, CACHE = 4'b0011, RESP_OKAY = 2'b00.
  - Reader state encoding.
  - This package is also usable by the writer.
- One natural sub-module: ddr_rd_burst_calc, a combinational min() of the four length terms.

Test Plan:
- Idle: reset with wr_word_ptr = 0 and rd_enable = 1 → no arvalid for 100 cycles; rd_word_ptr = 0.
- Basic: wr_word_ptr = 40, fifo_free = 1024 → bursts issued as arlen 15, 15, 7 at araddr 0x3000_0000, 0x3000_0040 and 0x3000_0080, with arid 1, 2, 3; 40 ordered fifo_wr beats; rd_word_ptr ends at 40.
- Wrap: reset_addr with wr_word_ptr = 0x3FF_FFFA, then wr_word_ptr = 0x000_0010 → arlen 5 at 0x3FFF_FFE8, then arlen 15 at 0x3000_0000; rd_word_ptr ends at 0x10.
- 4KB and space limits:
  - rd_ptr = 0x3F8, avail = 100 → arlen 7 at 0x3000_0FE0, next burst arlen 15 at 0x3000_1000.
  - fifo_free = 3 → arlen 2.
  - fifo_free = 0 → no arvalid.
- AR stall: arready held low for 20 cycles → arvalid stays high with araddr, arlen and arid stable; exactly one handshake occurs.
- Errors:
  - SLVERR on beat 4 → rresp_err = 1 and all 16 words are still written.
  - rlast on beat 10 of 16 → proto_err = 1, return to IDLE, rd_ptr advanced by 10.
  - rstn low mid-DATA → all outputs return to their reset values on the next edge.
